// File: rtl/sim_helper_pkg.sv
// Shared types and default constants for the simulation clock/time helper.
package sim_helper_pkg;

  typedef logic [63:0] sys_time_t;

  localparam int DEFAULT_DIV       = 4;
  localparam int DEFAULT_LOCK_CLKS = 8;
  localparam int CLK_PWM_FREQ      = 200000000;
  localparam int CLK_FREQ          = 50000000;

endpackage

// File: rtl/sim_helper_clk_div.sv
// Divides the master clock by DIV into a registered 50% duty clock plus a
// strobe that is high in the cycle whose closing edge raises the divided clock.
module clk_div
  import sim_helper_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic clk_out,
  output logic rise
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          clk_q, clk_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == CW'(DIV - 1));
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    clk_d     = (div_cnt_d < CW'(DIV / 2));
  end

  // Reset parks the counter at DIV-1 so the first edge after release is a rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= CW'(DIV - 1);
      clk_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_q     <= clk_d;
    end
  end

  assign clk_out = clk_q;
  assign rise    = wrap;

endmodule

// File: rtl/sim_helper.sv
// Derived logic clock, sticky lock indication and a 64-bit system time counter,
// all registered in the CLK_PWM domain.
module sim_helper
  import sim_helper_pkg::*;
#(
  parameter int        DIV           = DEFAULT_DIV,
  parameter int        LOCK_CLKS     = DEFAULT_LOCK_CLKS,
  parameter sys_time_t SYS_TIME_STEP = 64'd1,
  parameter sys_time_t SYS_TIME_INIT = 64'd0
) (
  input  logic      CLK_PWM,
  input  logic      RST,
  output logic      CLK,
  output logic      LOCKED,
  output sys_time_t SYS_TIME
);

  localparam int LW = $clog2(LOCK_CLKS + 1);

  logic          rise;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  sys_time_t     sys_time_q, sys_time_d;

  clk_div #(.DIV(DIV)) u_clk_div (
    .clk_i  (CLK_PWM),
    .rst_i  (RST),
    .clk_out(CLK),
    .rise   (rise)
  );

  // The rise that sets LOCKED does not advance time; only later rises do.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    sys_time_d = sys_time_q;
    if (rise) begin
      if (!locked_q) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        locked_d   = (lock_cnt_q == LW'(LOCK_CLKS - 1));
      end else begin
        sys_time_d = sys_time_q + SYS_TIME_STEP;
      end
    end
  end

  always_ff @(posedge CLK_PWM or posedge RST) begin
    if (RST) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      sys_time_q <= SYS_TIME_INIT;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      sys_time_q <= sys_time_d;
    end
  end

  assign LOCKED   = locked_q;
  assign SYS_TIME = sys_time_q;

endmodule

// File: tb/tb_sim_helper.sv
// Randomized reset/run bench for sim_helper: three parameterisations share one
// master clock and reset; a scoreboard checks every cycle against an edge-count model.
module tb_sim_helper;
  import sim_helper_pkg::*;

  localparam int ND = 3;

  logic      clk_pwm = 1'b0;
  logic      rst     = 1'b1;
  logic [ND-1:0] clk_v, lk_v;
  sys_time_t st0, st1, st2;

  sim_helper u_def (
    .CLK_PWM(clk_pwm), .RST(rst), .CLK(clk_v[0]), .LOCKED(lk_v[0]), .SYS_TIME(st0)
  );

  sim_helper #(.DIV(8), .LOCK_CLKS(2), .SYS_TIME_STEP(64'd20)) u_div8 (
    .CLK_PWM(clk_pwm), .RST(rst), .CLK(clk_v[1]), .LOCKED(lk_v[1]), .SYS_TIME(st1)
  );

  sim_helper #(.SYS_TIME_INIT(64'hFFFF_FFFF_FFFF_FFFE)) u_wrap (
    .CLK_PWM(clk_pwm), .RST(rst), .CLK(clk_v[2]), .LOCKED(lk_v[2]), .SYS_TIME(st2)
  );

  always #5 clk_pwm = ~clk_pwm;

  typedef struct {
    logic [ND-1:0]      c;
    logic [ND-1:0]      l;
    logic [ND-1:0][63:0] t;
    int                 n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   nprint = 0;

  int        p_div  [ND] = '{4, 8, 4};
  int        p_lock [ND] = '{8, 2, 8};
  sys_time_t p_step [ND] = '{64'd1, 64'd20, 64'd1};
  sys_time_t p_init [ND] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};

  // Behaviour as a function of n = CLK_PWM edges since reset release (0 = in reset).
  function automatic void model(input int n, input int d, input int lk, input sys_time_t step,
                                input sys_time_t init, output logic c, output logic l,
                                output sys_time_t t);
    int rises;
    rises = (n == 0) ? 0 : (n - 1) / d + 1;
    c = (n == 0) ? 1'b0 : (((n - 1) % d) < d / 2);
    l = (rises >= lk);
    t = init;
    if (rises > lk) t = init + step * sys_time_t'(rises - lk);
  endfunction

  int edges = 0;
  bit prev_rst = 1'b1;

  task automatic cycle(input bit r);
    exp_t e;
    @(posedge clk_pwm);
    #1;
    if (!prev_rst) edges++;
    rst = r;
    prev_rst = r;
    if (r) edges = 0;
    e.n = edges;
    for (int i = 0; i < ND; i++)
      model(edges, p_div[i], p_lock[i], p_step[i], p_init[i], e.c[i], e.l[i], e.t[i]);
    q.push_back(e);
  endtask

  task automatic check(input string name, input int dut, input int n,
                       input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (nprint < 30) begin
        nprint++;
        $display("FAIL %s dut%0d edge=%0d actual=%0h required=%0h", name, dut, n, act, req);
      end
    end
  endtask

  always @(negedge clk_pwm) begin
    if (q.size() > 0) begin
      exp_t e;
      sys_time_t st [ND];
      e = q.pop_front();
      st[0] = st0; st[1] = st1; st[2] = st2;
      for (int i = 0; i < ND; i++) begin
        check("clk",      i, e.n, 64'(clk_v[i]), 64'(e.c[i]));
        check("locked",   i, e.n, 64'(lk_v[i]),  64'(e.l[i]));
        check("sys_time", i, e.n, st[i],         e.t[i]);
      end
    end
  end

  initial begin
    repeat (10) cycle(1'b1);
    // Run until the default instance reaches SYS_TIME=500, then a one-cycle reset.
    repeat (2030) cycle(1'b0);
    cycle(1'b1);
    repeat (5100) cycle(1'b0);
    for (int k = 0; k < 12; k++) begin
      int hold, run;
      hold = $urandom_range(1, 3);
      run  = $urandom_range(5, 300);
      repeat (hold) cycle(1'b1);
      repeat (run) cycle(1'b0);
    end
    @(negedge clk_pwm);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sim_helper.md
SIM_HELPER -- requirements
Module: sim_helper

Interface
REQ-001 Parameter DIV, default 4, meaning CLK_PWM-to-CLK division ratio; SHALL be even and at least 2.
REQ-002 Parameter LOCK_CLKS, default 8, meaning the number of CLK periods after reset release before LOCKED asserts; SHALL be at least 1.
REQ-003 Parameter SYS_TIME_STEP, default 1, meaning the SYS_TIME increment per CLK rising edge; 64 bits wide.
REQ-004 Parameter SYS_TIME_INIT, default 0, meaning the SYS_TIME value at reset; 64 bits wide.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port CLK_PWM, input, 1 bit: the single master clock (200 MHz nominal).
REQ-007 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port CLK, output, 1 bit: derived logic clock (CLK_PWM/DIV, 50 MHz nominal), driven from a register.
REQ-009 Port LOCKED, output, 1 bit: clocks-stable indication; sticky high until reset.
REQ-010 Port SYS_TIME, output, 64 bits: system time counted in CLK periods.

Function
REQ-011 A divider counter div_cnt SHALL count 0..DIV-1 on every CLK_PWM rising edge and then wrap to 0.
REQ-012 CLK SHALL be registered, with next value 1 when next div_cnt < DIV/2, else 0.
- This gives a 50 % duty cycle and a period of exactly DIV CLK_PWM cycles.
REQ-013 A "CLK rise" event SHALL be the CLK_PWM edge at which div_cnt wraps from DIV-1 to 0; CLK goes 0->1 on that same edge.
REQ-014 A lock counter SHALL increment on each CLK rise while LOCKED=0.
REQ-015 LOCKED SHALL go to 1 on the CLK rise at which the lock count reaches LOCK_CLKS.
REQ-016 Once high, LOCKED SHALL remain 1 until RST; it SHALL never deassert otherwise.
REQ-017 SYS_TIME SHALL add SYS_TIME_STEP on every CLK rise at which LOCKED is already 1.
- The edge that sets LOCKED SHALL NOT increment SYS_TIME.
REQ-018 SYS_TIME SHALL use modulo-2^64 arithmetic and wrap silently from 2^64-1 to 0, with no flag.
REQ-019 All SYS_TIME, LOCKED and CLK transitions SHALL occur only on CLK_PWM rising edges, so CLK-domain consumers sample stable values.
REQ-020 SYS_TIME SHALL be constant between CLK rises.
REQ-021 No combinational path SHALL exist from any input to any output.

Reset
REQ-022 While RST=1, the block SHALL immediately hold: div_cnt=DIV-1, CLK=0, lock count=0, LOCKED=0, SYS_TIME=SYS_TIME_INIT.
REQ-023 On the first CLK_PWM edge after RST falls, div_cnt SHALL wrap to 0 and CLK SHALL rise; this counts as a CLK rise.
REQ-024 With defaults, LOCKED SHALL therefore assert on CLK_PWM edge number (LOCK_CLKS-1)*DIV+1 = 29 after release.
REQ-025 RST asserted mid-operation SHALL abort at once: CLK drops low asynchronously, LOCKED clears, and SYS_TIME reloads SYS_TIME_INIT.
- The full lock sequence then repeats after release.

Structure
REQ-026 A shared package sim_helper_pkg SHALL hold:
- typedef sys_time_t as a 64-bit logic vector;
- constants DEFAULT_DIV=4, DEFAULT_LOCK_CLKS=8, CLK_PWM_FREQ=200000000, CLK_FREQ=50000000.
REQ-027 The divider (div_cnt plus registered CLK plus the rise strobe) SHALL be one sub-module, clk_div, parameterised by DIV.
- clk_div outputs clk_out and rise.
REQ-028 The lock counter and SYS_TIME counter SHALL live in the sim_helper top.

Verification
REQ-029 Scenario, reset values: assert RST for 10 CLK_PWM cycles -> throughout, CLK=0, LOCKED=0, SYS_TIME=0.
REQ-030 Scenario, divider: release RST with DIV=4 -> CLK period is 4 CLK_PWM cycles, high 2 and low 2; first rise is on edge 1 after release.
REQ-031 Scenario, lock and count: defaults -> LOCKED rises on edge 29; SYS_TIME=0 at edge 29, 1 at edge 33, and 1250 after 1250 further CLK rises.
REQ-032 Scenario, wrap-around: SYS_TIME_INIT=2^64-2, SYS_TIME_STEP=1 -> after lock, successive CLK rises give 2^64-1, then 0, then 1.
REQ-033 Scenario, mid-operation reset: pulse RST for one cycle when SYS_TIME=500 -> CLK drops at once, LOCKED=0, SYS_TIME=0, and LOCKED re-asserts 29 edges after release.
REQ-034 Scenario, step and ratio: DIV=8, SYS_TIME_STEP=20, LOCK_CLKS=2 -> CLK period 8 cycles; LOCKED on edge 9; SYS_TIME=20 at edge 17 and 40 at edge 25.
